// File: rtl/cpu_pkg.sv
// Shared datapath encodings and constants for the phase-2 ALU path.
package cpu_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [DATA_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a radix-2 Booth step or a restoring-divide step.
module muldiv_step
  import cpu_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         op,
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic         q_m1,
  input  logic [W-1:0] m,
  output logic [W:0]   acc_n,
  output logic [W-1:0] q_n,
  output logic         qm1_n
);
  logic [W:0]   mx;
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W+1:0] diff;

  // Guard bit on acc keeps Booth add/sub of -2^(W-1) from overflowing.
  assign mx   = {m[W-1], m};
  assign sh   = {acc[W-1:0], q[W-1]};
  assign diff = {1'b0, sh} - {2'b00, m};

  always_comb begin
    sum   = acc;
    acc_n = acc;
    q_n   = q;
    qm1_n = q_m1;
    if (op == OP_MUL) begin
      case ({q[0], q_m1})
        2'b01:   sum = acc + mx;
        2'b10:   sum = acc - mx;
        default: sum = acc;
      endcase
      acc_n = {sum[W], sum[W:1]};
      q_n   = {sum[0], q[W-1:1]};
      qm1_n = q[0];
    end else if (!diff[W+1]) begin
      acc_n = diff[W:0];
      q_n   = {q[W-2:0], 1'b1};
    end else begin
      acc_n = sh;
      q_n   = {q[W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_muldiv32.sv
// Iterative signed multiply / divide: one add-sub per clock, start/busy/done handshake.
module seq_muldiv32
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_r;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic             qm1_n;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  muldiv_step #(.W(WIDTH)) u_step (
    .op    (op_r),
    .acc   (acc),
    .q     (q),
    .q_m1  (q_m1),
    .m     (m),
    .acc_n (acc_n),
    .q_n   (q_n),
    .qm1_n (qm1_n)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= OP_MUL;
      acc         <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      m           <= '0;
      a_r         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div0        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r        <= op;
          a_r         <= a;
          cnt         <= CW'(WIDTH);
          acc         <= '0;
          q_m1        <= 1'b0;
          div_by_zero <= 1'b0;
          if (op == OP_MUL) begin
            m     <= a;
            q     <= b;
            div0  <= 1'b0;
            state <= CALC;
          end else begin
            // Divide runs on magnitudes; signs are re-applied in FIX.
            m     <= mag(b);
            q     <= mag(a);
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
            div0  <= (b == '0);
            state <= (b == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= qm1_n;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          state <= IDLE;
          if (op_r == OP_MUL) begin
            result_hi <= acc[WIDTH-1:0];
            result_lo <= q;
          end else if (div0) begin
            div_by_zero <= 1'b1;
            result_hi   <= a_r;
            result_lo   <= WIDTH'(DIV0_QUOTIENT);
          end else begin
            result_hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            result_lo <= neg_q ? -q : q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_muldiv32.sv
// Scoreboard bench for seq_muldiv32: driver pushes expectations, monitor checks on done.
module tb_seq_muldiv32;
  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;

  seq_muldiv32 dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          e0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   ecnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   n_push = 0;
  int   nb;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clr === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", result_hi, result_lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, {32'h0, result_hi}, {32'h0, e.hi});
        chk({e.name, "_lo"}, {32'h0, result_lo}, {32'h0, e.lo});
        chk({e.name, "_dbz"}, {63'h0, div_by_zero}, {63'h0, e.dbz});
        chk({e.name, "_latency"}, 64'(ecnt - e.e0), 64'(e.lat));
        chk({e.name, "_busy_at_done"}, {63'h0, busy}, 64'h0);
      end
    end
  end

  // Called at a negedge; start is seen by the following posedge (E0).
  task automatic issue(input string nm, input logic o, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat, input bit push);
    exp_t e;
    op = o; a = ai; b = bi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.hi = eh; e.lo = el; e.dbz = ed; e.e0 = ecnt; e.lat = lat; e.name = nm;
      sb.push_back(e);
      n_push++;
    end
  endtask

  // Counts negedges with busy high; returns at the negedge where busy has dropped.
  task automatic run_wait(input string nm, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      nbusy++;
    end
    chk({nm, "_timeout"}, 64'(nbusy), 64'd33);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_dbz", {63'h0, div_by_zero}, 64'h0);
    chk("reset_hi", {32'h0, result_hi}, 64'h0);
    chk("reset_lo", {32'h0, result_lo}, 64'h0);
    clr = 1'b1;
    @(negedge clk);

    issue("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
    run_wait("mul_7_m3", nb);
    @(negedge clk);
    issue("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, 1'b1);
    run_wait("mul_min_min", nb);
    chk("mul_min_min_busy_cycles", 64'(nb), 64'd33);
    @(negedge clk);
    issue("div_m17_5", 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
    run_wait("div_m17_5", nb);
    @(negedge clk);
    issue("div_9_0", 1'b1, 32'd9, 32'd0, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    run_wait("div_9_0", nb);
    chk("div_9_0_busy_cycles", 64'(nb), 64'd1);
    @(negedge clk);
    chk("dbz_held", {63'h0, div_by_zero}, 64'h1);
    issue("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 1'b1);
    run_wait("div_min_m1", nb);
    @(negedge clk);
    issue("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
    run_wait("div_7_m2", nb);

    // Stray starts while busy must be dropped.
    @(negedge clk);
    issue("mul_ignore", 1'b0, 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FFFF, 32'hFFF0_BDC0, 1'b0, 33, 1'b1);
    repeat (2) @(negedge clk);
    op = 1'b1; a = 32'd5; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    op = 1'b1; a = 32'd3; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait("mul_ignore", nb);

    // Abort mid-operation: no done, outputs cleared.
    @(negedge clk);
    issue("abort", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 1'b0, 33, 1'b0);
    repeat (9) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("abort_hi", {32'h0, result_hi}, 64'h0);
    chk("abort_lo", {32'h0, result_lo}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    clr = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", {63'h0, busy}, 64'h0);
    issue("mul_after_abort", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, 1'b1);
    run_wait("mul_after_abort", nb);

    // Back-to-back: second start lands in the done cycle.
    @(negedge clk);
    issue("b2b_mul", 1'b0, 32'd6, 32'd6, 32'h0, 32'd36, 1'b0, 33, 1'b1);
    run_wait("b2b_mul", nb);
    chk("b2b_done_cycle", {63'h0, done}, 64'h1);
    issue("b2b_div", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
    run_wait("b2b_div", nb);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    chk("done_count", 64'(done_cnt), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
